mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory port between instruction fetch and the data access of the memory stage.
- Serialises requests with a 3-state FSM. Each requester gets a one-cycle done pulse and registered read data.
- Drives the global stall that feeds longest_stall in the pipeline controller, so all stages freeze while any access is outstanding.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
inst_req  input  1  fetch request, level; held until inst_done seen
inst_addr  input  ADDR_W  fetch address
inst_rdata  output  DATA_W  fetched word, registered
inst_done  output  1  one-cycle pulse: fetch complete
data_req  input  1  load/store request, level; held until data_done seen
data_wr  input  1  1 = store, 0 = load
data_size  input  2  0 byte, 1 half, 2 word; passed through unchanged
data_addr  input  ADDR_W  load/store address
data_wdata  input  DATA_W  store data
data_rdata  output  DATA_W  load data, registered
data_done  output  1  one-cycle pulse: access complete
mem_req  output  1  memory request valid
mem_wr  output  1  write strobe
mem_size  output  2  access size
mem_addr  output  ADDR_W  address
mem_wdata  output  DATA_W  write data
mem_addr_ok  input  1  memory accepted the request this cycle
mem_data_ok  input  1  memory returns data / write ack this cycle
mem_rdata  input  DATA_W  read data, valid with mem_data_ok
stall  output  1  combinational: (inst_req & ~inst_done) | (data_req & ~data_done)

Behaviour:
- Reset: state IDLE, grant_data=0, last_was_data=0. mem_req, inst_done, data_done = 0. inst_rdata, data_rdata, and latched request registers = 0.
- FSM states are IDLE, ADDR and WAIT.
- IDLE:
  - A requester is eligible when its req=1 and its done=0 in this cycle. This prevents re-issuing a request the requester has not yet dropped.
  - If both are eligible: grant inst when last_was_data=1, else grant data (data priority with anti-starvation). If only one is eligible, grant it.
  - On grant: latch addr, wr, size and wdata (inst: wr=0, size=2, wdata=0), set grant_data and last_was_data, then go to ADDR.
  - If neither is eligible, stay in IDLE.
- ADDR:
  - mem_req=1; mem_* outputs are driven from the latched registers, never directly from requester inputs.
  - On mem_addr_ok: if mem_data_ok is also high in the same cycle, complete as in WAIT; else go to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_data_ok: capture mem_rdata into inst_rdata or data_rdata per grant_data, pulse that requester's done for exactly the next cycle, and go to IDLE.
  - For stores, data_rdata is also overwritten with mem_rdata (don't-care value).
- Latency: best case 2 cycles from grant (ADDR+data_ok same cycle) to done visible. Done is asserted in the IDLE cycle after completion; the next grant can occur in that same IDLE cycle, but only to the other requester or a new request.
- done outputs are registered, high at most one cycle. rdata holds its value until the next completion for that requester.
- Requester input changes while granted do not affect the memory port.
- mem_addr_ok outside ADDR and mem_data_ok outside ADDR/WAIT are ignored.
- rst mid-transaction: return to IDLE at the next edge with all outputs at reset values. A late mem_data_ok afterwards is ignored.
- At most one outstanding memory transaction; no address/alignment checking.

Test Plan:
- Reset, then inst_req=1 addr 0xBFC00000; memory gives addr_ok after 1 cycle and data_ok 2 cycles later with 0x3C080001 -> one mem_req with mem_wr=0, mem_size=2; inst_done pulses once; inst_rdata=0x3C080001; stall drops the same cycle as inst_done.
- inst_req and data_req (load, addr 0x80001000) raised in the same cycle, last_was_data=0 -> data granted first; inst granted in the IDLE cycle carrying data_done; data_done and inst_done never coincide.
- Back-to-back data requests with inst_req held high -> grants alternate data, inst, data; inst is never starved.
- Store of byte 0xAB to 0x80002003 with addr_ok and data_ok in the same cycle -> mem_wr=1, mem_size=0, mem_wdata=0xAB; data_done one cycle later; total 2 cycles.
- rst asserted in WAIT, memory then returns data_ok -> mem_req=0, no done pulse, state IDLE; next inst_req serviced normally.
- Requester holds req high during its done cycle -> no second mem_req issued for it.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// One outstanding transaction at a time; data has priority, alternating when both wait.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

  state_e              state_q, state_d;
  logic                grant_data_q, grant_data_d;
  logic                last_was_data_q, last_was_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_done_q, inst_done_d;
  logic                data_done_q, data_done_d;

  logic inst_elig, data_elig, pick_data, complete;

  // A requester still holding req during its done cycle must not be re-granted.
  assign inst_elig = inst_req & ~inst_done_q;
  assign data_elig = data_req & ~data_done_q;

  always_comb begin
    state_d         = state_q;
    grant_data_d    = grant_data_q;
    last_was_data_d = last_was_data_q;
    addr_d          = addr_q;
    wr_d            = wr_q;
    size_d          = size_q;
    wdata_d         = wdata_q;
    inst_rdata_d    = inst_rdata_q;
    data_rdata_d    = data_rdata_q;
    inst_done_d     = 1'b0;
    data_done_d     = 1'b0;
    mem_req         = 1'b0;
    pick_data       = 1'b0;
    complete        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (inst_elig || data_elig) begin
          pick_data       = data_elig & (~inst_elig | ~last_was_data_q);
          grant_data_d    = pick_data;
          last_was_data_d = pick_data;
          if (pick_data) begin
            addr_d  = data_addr;
            wr_d    = data_wr;
            size_d  = data_size;
            wdata_d = data_wdata;
          end else begin
            addr_d  = inst_addr;
            wr_d    = 1'b0;
            size_d  = 2'd2;
            wdata_d = '0;
          end
          state_d = StAddr;
        end
      end
      StAddr: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            complete = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_data_ok) begin
          complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      state_d = StIdle;
      if (grant_data_q) begin
        data_rdata_d = mem_rdata;
        data_done_d  = 1'b1;
      end else begin
        inst_rdata_d = mem_rdata;
        inst_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      grant_data_q    <= 1'b0;
      last_was_data_q <= 1'b0;
      addr_q          <= '0;
      wr_q            <= 1'b0;
      size_q          <= 2'd0;
      wdata_q         <= '0;
      inst_rdata_q    <= '0;
      data_rdata_q    <= '0;
      inst_done_q     <= 1'b0;
      data_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_data_q    <= grant_data_d;
      last_was_data_q <= last_was_data_d;
      addr_q          <= addr_d;
      wr_q            <= wr_d;
      size_q          <= size_d;
      wdata_q         <= wdata_d;
      inst_rdata_q    <= inst_rdata_d;
      data_rdata_q    <= data_rdata_d;
      inst_done_q     <= inst_done_d;
      data_done_q     <= data_done_d;
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign mem_wr     = wr_q;
  assign mem_size   = size_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign stall      = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the arbiter and a behavioural memory responder.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_done, data_req, data_wr, data_done;
  logic [AW-1:0] inst_addr, data_addr, mem_addr;
  logic [DW-1:0] inst_rdata, data_rdata, data_wdata, mem_wdata, mem_rdata;
  logic [1:0]    data_size, mem_size;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok, stall;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_size  (data_size),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata  (mem_rdata),
    .stall      (stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_resp(input logic aok, input logic dok, input logic [31:0] rd);
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  // Transaction-level model: phase 0 none, 1 waiting addr_ok, 2 waiting data_ok
  int            m_phase, lat;
  bit            m_gdata, m_last_data, ie, de, g, cmp;
  bit            exp_idone, exp_ddone, nxt_idone, nxt_ddone;
  logic [31:0]   m_addr, m_wdata, exp_irdata, exp_drdata;
  bit            m_wr;
  logic [1:0]    m_size;
  logic [31:0]   exp_seq;

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_resp(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_done", inst_done, 0);
    chk("rst_data_done", data_done, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    tick();

    // Fetch with addr_ok after one cycle, data_ok two cycles later
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1 chk("f_stall_req", stall, 1);
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_wr", mem_wr, 0);
    chk("f_mem_size", mem_size, 2);
    chk("f_mem_addr", mem_addr, 32'hBFC0_0000);
    tick();
    chk("f_mem_req_hold", mem_req, 1);
    mem_resp(1'b1, 1'b0, 32'h0);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("f_wait_mem_req", mem_req, 0);
    chk("f_wait_stall", stall, 1);
    tick();
    chk("f_no_early_done", inst_done, 0);
    mem_resp(1'b0, 1'b1, 32'h3C08_0001);
    tick();
    mem_resp(1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("f_done", inst_done, 1);
    chk("f_rdata", inst_rdata, 32'h3C08_0001);
    chk("f_stall_drop", stall, 0);
    tick();
    chk("f_done_pulse", inst_done, 0);
    chk("f_no_reissue", mem_req, 0);
    inst_req = 0;
    tick();
    chk("f_rdata_hold", inst_rdata, 32'h3C08_0001);

    // Simultaneous requests: data first, inst granted in the data_done cycle
    inst_req = 1; inst_addr = 32'h0000_0100;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_1000;
    tick();
    chk("b_first_addr", mem_addr, 32'h8000_1000);
    chk("b_first_wr", mem_wr, 0);
    mem_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("b_data_done", data_done, 1);
    chk("b_inst_not_done", inst_done, 0);
    chk("b_data_rdata", data_rdata, 32'hDEAD_BEEF);
    data_req = 0;
    tick();
    chk("b_second_req", mem_req, 1);
    chk("b_second_addr", mem_addr, 32'h0000_0100);
    chk("b_data_done_pulse", data_done, 0);
    mem_resp(1'b1, 1'b1, 32'h1111_1111);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("b_inst_done", inst_done, 1);
    chk("b_data_quiet", data_done, 0);
    chk("b_inst_rdata", inst_rdata, 32'h1111_1111);
    inst_req = 0;
    tick();

    // Both held high: grants alternate data, inst, data, ...
    inst_req = 1; inst_addr = 32'h0000_0200;
    data_req = 1; data_addr = 32'h8000_3000;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_seq = (k % 2 == 0) ? 32'h8000_3000 : 32'h0000_0200;
      chk("alt_mem_req", mem_req, 1);
      chk("alt_mem_addr", mem_addr, exp_seq);
      mem_resp(1'b1, 1'b1, 32'(k));
      tick();
      mem_resp(1'b0, 1'b0, 32'h0);
      chk("alt_data_done", data_done, (k % 2 == 0) ? 1 : 0);
      chk("alt_inst_done", inst_done, (k % 2 == 0) ? 0 : 1);
      if (k == 5) begin
        inst_req = 0;
        data_req = 0;
      end
      tick();
    end
    chk("alt_idle", mem_req, 0);

    // Byte store with addr_ok and data_ok together
    data_req = 1; data_wr = 1; data_size = 2'd0;
    data_addr = 32'h8000_2003; data_wdata = 32'h0000_00AB;
    tick();
    chk("s_mem_wr", mem_wr, 1);
    chk("s_mem_size", mem_size, 0);
    chk("s_mem_wdata", mem_wdata, 32'h0000_00AB);
    chk("s_mem_addr", mem_addr, 32'h8000_2003);
    mem_resp(1'b1, 1'b1, 32'h55AA_55AA);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("s_done", data_done, 1);
    chk("s_rdata_overwrite", data_rdata, 32'h55AA_55AA);
    data_req = 0; data_wr = 0;
    tick();
    chk("s_done_pulse", data_done, 0);

    // Reset while waiting for data; the late data_ok must be ignored
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    tick();
    mem_resp(1'b1, 1'b0, 32'h0);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("r_wait_mem_req", mem_req, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("r_mem_req", mem_req, 0);
    chk("r_inst_done", inst_done, 0);
    chk("r_inst_rdata", inst_rdata, 0);
    chk("r_data_rdata", data_rdata, 0);
    inst_req = 0;
    mem_resp(1'b0, 1'b1, 32'h9999_9999);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("r_late_done", inst_done, 0);
    chk("r_late_rdata", inst_rdata, 0);
    chk("r_late_mem_req", mem_req, 0);
    inst_req = 1; inst_addr = 32'hBFC0_0020;
    tick();
    chk("r_again_req", mem_req, 1);
    chk("r_again_addr", mem_addr, 32'hBFC0_0020);
    mem_resp(1'b1, 1'b1, 32'h1234_5678);
    tick();
    mem_resp(1'b0, 1'b0, 32'h0);
    chk("r_again_done", inst_done, 1);
    chk("r_again_rdata", inst_rdata, 32'h1234_5678);
    inst_req = 0;
    tick();

    // Randomized run
    rst = 1;
    tick();
    rst = 0;
    m_phase = 0; m_last_data = 0; m_gdata = 0; lat = 0;
    exp_idone = 0; exp_ddone = 0; exp_irdata = '0; exp_drdata = '0;
    m_addr = '0; m_wdata = '0; m_wr = 0; m_size = 2'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      chk("rnd_inst_done", inst_done, exp_idone);
      chk("rnd_data_done", data_done, exp_ddone);
      chk("rnd_inst_rdata", inst_rdata, exp_irdata);
      chk("rnd_data_rdata", data_rdata, exp_drdata);
      chk("rnd_mem_req", mem_req, (m_phase == 1) ? 1 : 0);
      if (m_phase == 1) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_wr", mem_wr, m_wr);
        chk("rnd_mem_size", mem_size, m_size);
        chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end

      // Requesters: issue, hold until done, and wiggle inputs once granted
      if (!inst_req || exp_idone) begin
        inst_req = ($urandom_range(0, 2) == 0);
        inst_addr = $urandom;
      end else if (m_phase != 0 && !m_gdata && $urandom_range(0, 3) == 0) begin
        inst_addr = $urandom;
      end
      if (!data_req || exp_ddone) begin
        data_req = ($urandom_range(0, 2) == 0);
        data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
      end else if (m_phase != 0 && m_gdata && $urandom_range(0, 3) == 0) begin
        data_addr = $urandom; data_wdata = $urandom;
        data_wr = ~data_wr; data_size = 2'($urandom_range(0, 3));
      end

      // Memory responder, including stray handshakes while nothing is pending
      mem_resp(1'b0, 1'b0, $urandom);
      if (m_phase == 0) begin
        mem_addr_ok = ($urandom_range(0, 3) == 0);
        mem_data_ok = ($urandom_range(0, 3) == 0);
      end else if (m_phase == 1) begin
        mem_addr_ok = ($urandom_range(0, 1) == 0);
        mem_data_ok = mem_addr_ok && ($urandom_range(0, 2) == 0);
      end else begin
        if (lat == 0) mem_data_ok = 1;
        else lat--;
      end

      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        inst_req = 0;
        data_req = 0;
      end
      #1 chk("rnd_stall", stall, (inst_req & ~exp_idone) | (data_req & ~exp_ddone));

      // Expected outcome of the coming edge
      nxt_idone = 0; nxt_ddone = 0; cmp = 0;
      if (rst) begin
        m_phase = 0; m_last_data = 0; m_gdata = 0;
        exp_irdata = '0; exp_drdata = '0;
        m_addr = '0; m_wdata = '0; m_wr = 0; m_size = 2'd0;
      end else if (m_phase == 0) begin
        ie = inst_req & ~exp_idone;
        de = data_req & ~exp_ddone;
        if (ie || de) begin
          g = de && (!ie || !m_last_data);
          m_gdata = g; m_last_data = g;
          if (g) begin
            m_addr = data_addr; m_wr = data_wr; m_size = data_size; m_wdata = data_wdata;
          end else begin
            m_addr = inst_addr; m_wr = 0; m_size = 2'd2; m_wdata = '0;
          end
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_addr_ok && mem_data_ok) cmp = 1;
        else if (mem_addr_ok) begin
          m_phase = 2;
          lat = $urandom_range(0, 3);
        end
      end else if (mem_data_ok) begin
        cmp = 1;
      end
      if (cmp) begin
        m_phase = 0;
        if (m_gdata) begin
          exp_drdata = mem_rdata; nxt_ddone = 1;
        end else begin
          exp_irdata = mem_rdata; nxt_idone = 1;
        end
      end
      exp_idone = nxt_idone;
      exp_ddone = nxt_ddone;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
